// File: rtl/spi_pkg.sv
// Shared definitions for the SPI monarch and its users.
//   spi_state_t : monarch FSM states (IDLE, FRONT, SHIFT)
//   SPI_LEN     : bits per transaction
package spi_pkg;

   localparam int unsigned SPI_LEN = 16;

   typedef enum logic [1:0] {
      IDLE,
      FRONT,
      SHIFT
   } spi_state_t;

endpackage

// File: rtl/spi_mnrch_if.sv
// Bundle between a host (e.g. inert_intf), the SPI monarch and the sensor pins.
//   snd  : single-cycle transaction request      cmd  : word to send
//   done : transaction complete (sticky)          resp : word received
//   SS_n : slave select (active low)              SCLK : serial clock (idles high)
//   MOSI : monarch-out data                       MISO : slave-out data
// modport master is the monarch's view; modport slave is the complementary view.
interface spi_mnrch_if;
   import spi_pkg::*;

   logic               snd;
   logic [SPI_LEN-1:0] cmd;
   logic               done;
   logic [SPI_LEN-1:0] resp;
   logic               SS_n;
   logic               SCLK;
   logic               MOSI;
   logic               MISO;

   modport master (
      input  snd, cmd, MISO,
      output done, resp, SS_n, SCLK, MOSI
   );

   modport slave (
      output snd, cmd, MISO,
      input  done, resp, SS_n, SCLK, MOSI
   );

endinterface

// File: rtl/spi_mnrch.sv
// SPI monarch: one 16-bit full-duplex transaction per snd pulse.
// Mode 3 (SCLK idles high, MOSI changes on fall, MISO captured at rise), MSB first.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : spi_mnrch_if.master (snd/cmd in, done/resp out, SS_n/SCLK/MOSI/MISO pins)
// SCLK period is 2^DIV_W clk cycles.
module spi_mnrch
   import spi_pkg::*;
#(
   parameter int unsigned DIV_W = 5
) (
   input logic          clk,
   input logic          rst_n,
   spi_mnrch_if.master  bus
);

   localparam int unsigned DivLen = 1 << DIV_W;
   // Preload places the first SCLK fall a quarter period after SS_n drops.
   localparam logic [DIV_W-1:0] DivPre = DIV_W'(DivLen - DivLen / 4 - 1);
   localparam logic [DIV_W-1:0] DivSmp = {1'b0, {(DIV_W - 1){1'b1}}};
   localparam logic [4:0]       LastBit = 5'(SPI_LEN - 1);

   spi_state_t         state_q, state_d;
   logic [DIV_W-1:0]   div_q;
   logic [4:0]         bit_cnt_q;
   logic [SPI_LEN-1:0] shift_q;
   logic               miso_smpl_q;
   logic               done_q;
   logic               ss_n_q;

   logic smpl_evt, shft_evt;
   logic start, shift_en, finish, div_hold;

   assign smpl_evt = (div_q == DivSmp); // SCLK about to rise
   assign shft_evt = &div_q;            // SCLK about to fall

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.snd)  state_d = FRONT;
         FRONT:   if (shft_evt) state_d = SHIFT;
         SHIFT:   if (finish)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: control strobes
   always_comb begin
      start    = 1'b0;
      shift_en = 1'b0;
      finish   = 1'b0;
      div_hold = 1'b0;
      case (state_q)
         IDLE: begin
            div_hold = 1'b1;
            start    = bus.snd;
         end
         FRONT: ; // first fall only; nothing captured yet
         SHIFT: begin
            shift_en = shft_evt;
            finish   = shft_evt && (bit_cnt_q == LastBit);
            // Reload on the last edge so no 17th fall is produced.
            div_hold = finish;
         end
         default: div_hold = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        div_q <= DivPre;
      else if (div_hold) div_q <= DivPre;
      else               div_q <= div_q + DIV_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        bit_cnt_q <= '0;
      else if (start)    bit_cnt_q <= '0;
      else if (shift_en) bit_cnt_q <= bit_cnt_q + 5'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        shift_q <= '0;
      else if (start)    shift_q <= bus.cmd;
      else if (shift_en) shift_q <= {shift_q[SPI_LEN-2:0], miso_smpl_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        miso_smpl_q <= 1'b0;
      else if (smpl_evt) miso_smpl_q <= bus.MISO;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      done_q <= 1'b0;
      else if (start)  done_q <= 1'b0;
      else if (finish) done_q <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ss_n_q <= 1'b1;
      else if (start)  ss_n_q <= 1'b0;
      else if (finish) ss_n_q <= 1'b1;
   end

   assign bus.SCLK = div_q[DIV_W-1];
   assign bus.MOSI = shift_q[SPI_LEN-1];
   assign bus.resp = shift_q;
   assign bus.done = done_q;
   assign bus.SS_n = ss_n_q;

endmodule

// File: tb/tb_spi_mnrch.sv
// Self-checking bench for spi_mnrch: a mode-3 slave model on the DIV_W=5 instance and
// a loopback DIV_W=4 instance.
module tb_spi_mnrch;
   import spi_pkg::*;

   localparam int D5   = 32;
   localparam int D4   = 16;
   localparam int Lat5 = D5 / 4 + 1 + SPI_LEN * D5;
   localparam int Lat4 = D4 / 4 + 1 + SPI_LEN * D4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_mnrch_if bus5 ();
   spi_mnrch_if bus4 ();

   logic        lb       = 1'b1;
   logic        slv_bit  = 1'b0;
   logic [15:0] slv_word = 16'h0;

   assign bus5.MISO = lb ? bus5.MOSI : slv_bit;
   assign bus4.MISO = bus4.MOSI;

   spi_mnrch #(.DIV_W(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
   spi_mnrch #(.DIV_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Slave model: presents word bits MSB first, one per SCLK fall; records MOSI at rises.
   int          falls     = 0;
   int          fidx      = 0;
   logic [15:0] mosi_seen = 16'h0;
   logic        ss_prev   = 1'b1;
   logic        sclk_prev = 1'b1;
   always @(bus5.SS_n or bus5.SCLK) begin
      if (ss_prev === 1'b1 && bus5.SS_n === 1'b0) begin
         fidx      = 0;
         mosi_seen = 16'h0;
      end
      if (sclk_prev === 1'b1 && bus5.SCLK === 1'b0) begin
         falls++;
         if (bus5.SS_n === 1'b0 && fidx < 16) begin
            slv_bit = slv_word[15 - fidx];
            fidx++;
         end
      end
      if (sclk_prev === 1'b0 && bus5.SCLK === 1'b1 && bus5.SS_n === 1'b0)
         mosi_seen = {mosi_seen[14:0], bus5.MOSI};
      ss_prev   = bus5.SS_n;
      sclk_prev = bus5.SCLK;
   end

   // SCLK must stay high whenever the slave is deselected.
   int idle_bad = 0;
   always @(negedge clk)
      if (rst_n === 1'b1 && bus5.SS_n === 1'b1 && bus5.SCLK !== 1'b1) idle_bad++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic start5(input logic [15:0] c, input logic [15:0] sw);
      slv_word  = sw;
      bus5.cmd  = c;
      bus5.snd  = 1'b1;
      @(posedge clk);
      #1;
      bus5.snd = 1'b0;
      check("start_done_low", {31'h0, bus5.done}, 32'h0);
      check("start_ss_low", {31'h0, bus5.SS_n}, 32'h0);
      check("start_mosi_msb", {31'h0, bus5.MOSI}, {31'h0, c[15]});
   endtask

   // Waits for done; optionally pulses snd at the given cycle counts.
   task automatic wait5(input int pa, input int pb, output int lat);
      lat = 0;
      while (bus5.done !== 1'b1 && lat < 2000) begin
         if (lat == pa || lat == pb) begin
            bus5.cmd = ~bus5.cmd;
            bus5.snd = 1'b1;
         end
         @(posedge clk);
         #1;
         bus5.snd = 1'b0;
         lat++;
      end
   endtask

   task automatic run5(input logic [15:0] c, input logic [15:0] sw, input logic [15:0] exp,
                       input int pa, input int pb);
      int f0, lat;
      f0 = falls;
      start5(c, sw);
      wait5(pa, pb, lat);
      check("latency", lat, Lat5);
      check("resp", {16'h0, bus5.resp}, {16'h0, exp});
      check("mosi_bits", {16'h0, mosi_seen}, {16'h0, c});
      check("sclk_falls", falls - f0, 16);
      check("ss_high_at_done", {31'h0, bus5.SS_n}, 32'h1);
      check("sclk_high_at_done", {31'h0, bus5.SCLK}, 32'h1);
   endtask

   task automatic run4(input logic [15:0] c);
      int lat;
      bus4.cmd = c;
      bus4.snd = 1'b1;
      @(posedge clk);
      #1;
      bus4.snd = 1'b0;
      lat = 0;
      while (bus4.done !== 1'b1 && lat < 1000) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("d4_latency", lat, Lat4);
      check("d4_resp", {16'h0, bus4.resp}, {16'h0, c});
   endtask

   initial begin
      logic [15:0] c, sw, sw2;
      bus5.snd = 1'b0;
      bus5.cmd = 16'h0;
      bus4.snd = 1'b0;
      bus4.cmd = 16'h0;
      rst_n    = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      check("rst_ss", {31'h0, bus5.SS_n}, 32'h1);
      check("rst_sclk", {31'h0, bus5.SCLK}, 32'h1);
      check("rst_done", {31'h0, bus5.done}, 32'h0);
      check("rst_resp", {16'h0, bus5.resp}, 32'h0);
      check("rst_mosi", {31'h0, bus5.MOSI}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Loopback
      lb = 1'b1;
      run5(16'hA5C3, 16'h0000, 16'hA5C3, -1, -1);

      // WHO_AM_I-style read
      lb = 1'b0;
      run5(16'h8F00, 16'h8D17, 16'h8D17, -1, -1);

      // Back-to-back: second snd one cycle after done
      sw  = 16'($urandom);
      sw2 = 16'($urandom);
      run5(16'h0001, sw, sw, -1, -1);
      run5(16'hFFFE, sw2, sw2, -1, -1);

      // snd pulses during an active transaction are ignored
      c  = 16'($urandom);
      sw = 16'($urandom);
      run5(c, sw, sw, 100, 300);

      // Random transactions
      for (int i = 0; i < 3; i++) begin
         c  = 16'($urandom);
         sw = 16'($urandom);
         run5(c, sw, sw, -1, -1);
      end

      // Reset mid-transaction
      start5(16'h3C5A, 16'h1234);
      repeat (200) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_ss", {31'h0, bus5.SS_n}, 32'h1);
      check("midrst_sclk", {31'h0, bus5.SCLK}, 32'h1);
      check("midrst_done", {31'h0, bus5.done}, 32'h0);
      check("midrst_resp", {16'h0, bus5.resp}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      c  = 16'($urandom);
      sw = 16'($urandom);
      run5(c, sw, sw, -1, -1);

      // Loopback with a random word
      lb = 1'b1;
      c  = 16'($urandom);
      run5(c, 16'h0000, c, -1, -1);

      // DIV_W=4 instance
      run4(16'hC3A5);
      run4(16'($urandom));

      check("sclk_idle_high", idle_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_mnrch.md
Name: spi_mnrch

Overview:
SPI monarch (master) that runs one 16-bit full-duplex transaction per request. It sits directly upstream of inert_intf, which issues gyro register reads/writes through it (cmd/snd in, resp/done out) and drives the sensor pins SS_n/SCLK/MOSI/MISO. The mode is fixed: CPOL=1, CPHA=1 (SCLK idles high, MOSI changes on the falling edge, MISO is captured at the rising edge), MSB first.

Parameters:
DIV_W, 5, width of the SCLK divider counter; SCLK period = 2^DIV_W clk cycles (32 by default).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
snd  input  1  single-cycle request to start a transaction; honoured only when idle
cmd  input  16  word to transmit, captured on the edge that samples snd
done  output  1  transaction complete; held high until the next accepted snd
resp  output  16  word received from MISO, valid while done=1
SS_n  output  1  slave select, active low
SCLK  output  1  serial clock = MSB of divider
MOSI  output  1  shift register bit 15
MISO  input  1  serial data from slave

Behaviour:
- Reset values: SS_n=1, done=0, SCLK=1, shift register=0 (MOSI=0, resp=0), divider preloaded, state=IDLE. All registers are flopped; SS_n and done use reset/preset flops (glitch-free).
- D=2^DIV_W. The divider preload value is PRE = D - D/4 - 1 (23 for D=32). In IDLE the divider is held at PRE, so SCLK=1. Outside IDLE the divider increments every clk. SCLK = div[DIV_W-1].
- States: IDLE, FRONT, SHIFT (BACK is folded into the final SHIFT edge).
- IDLE: when snd=1, on that edge (edge 0): shift_reg<=cmd, bit_cnt<=0, done<=0, SS_n<=0, go FRONT. A snd in FRONT/SHIFT is ignored.
- Sample event: div == {0,1...1} (SCLK about to rise). On that edge miso_smpl<=MISO.
- Shift event: div == all ones (SCLK about to fall).
- FRONT: the first shift event is suppressed (no shift, no count). It is the first SCLK fall, at edge D/4+1 (edge 9). Go to SHIFT.
- SHIFT: each shift event does shift_reg<={shift_reg[14:0],miso_smpl} and bit_cnt++. When the event occurs with bit_cnt==15 (16th shift, at edge D/4+1+16*D = 521):
  - perform the shift;
  - done<=1, SS_n<=1;
  - reload div to PRE so that no 17th SCLK fall appears;
  - go IDLE.
- Result: exactly 16 SCLK low pulses per transaction. The first fall occurs with SS_n already low for D/4 cycles. SCLK is high at SS_n deassert.
- resp = shift_reg. After done it equals the 16 MISO bits in arrival order (first bit = resp[15]). MOSI = shift_reg[15], so cmd[15] is present from edge 0.
- snd on the same edge that done rises: ignored (state is still SHIFT). snd on any later edge starts a new transaction and clears done.
- Reset asserted mid-transaction: everything returns immediately to reset values. No partial done.
- bit_cnt is 5 bits wide and must not wrap within a transaction.

Decomposition:
- Shared package (spi_pkg): state enum spi_state_t {IDLE,FRONT,SHIFT}, localparam SPI_LEN=16.
- No sub-module. The divider, bit counter, shift register and FSM are each a small always block in one module. A reusable sensor-side SPI slave model (spi_iNEMO-style) belongs in the testbench, not RTL.

Test Plan:
- Loopback (MISO tied to MOSI), cmd=16'hA5C3, snd pulse → exactly 16 SCLK falls; done rises 521 clks after snd edge; resp=16'hA5C3; SS_n high with done; SCLK=1 throughout idle.
- Slave model returns 16'h8D17 for cmd=16'h8F00 (WHO_AM_I-style read) → MOSI bits observed at SCLK rises = 8F00 MSB first; resp=16'h8D17.
- Back-to-back: snd for 16'h0001 then snd 1 clk after done for 16'hFFFE → second transaction starts, done drops on that edge, second resp matches slave data, no extra SCLK edge between frames.
- snd pulsed at clk 100 and 300 during an active transaction → ignored; SCLK count still 16; resp unchanged from single-transaction expectation.
- rst_n asserted at clk 200 mid-transaction → SS_n=1, SCLK=1, done=0, resp=0 immediately; a following snd completes normally.
- DIV_W=4 instance → SCLK period 16 clks, done at edge 4+1+16*16=261, loopback resp correct.
